dram_resp: RTL and testbench
============================

// Module: dram_resp
// PURPOSE
//  DRAM-side responder for the layer-engine memory protocol (dram_en_rd/dram_en_wr/dram_valid).
//  Serves one initiator (relu, conv, pool engines via top-level mux). Reads complete after a fixed latency
//  with a one-cycle dram_valid pulse; writes commit in the cycle they are presented.
//  Holds word storage internally; used as the on-chip DRAM model in the top-level and in block benches.
// PARAMETERS
//  DATA_WIDTH  32  word width
//  ADDR_WIDTH  18  address width of addr_rd/addr_wr
//  MEM_DEPTH   2**ADDR_WIDTH  words stored; address index = addr mod MEM_DEPTH (low bits)
//  RD_LATENCY  2   cycles from accepted read to dram_valid; legal range 1..15
// PORTS
//  clk         in   1           clock; all logic on rising edge
//  srstn       in   1           synchronous reset, active low
//  dram_en_rd  in   1           read request (level sampled)
//  addr_rd     in   ADDR_WIDTH  read address, sampled with accepted dram_en_rd
//  dram_en_wr  in   1           write strobe
//  addr_wr     in   ADDR_WIDTH  write address
//  data_wr     in   DATA_WIDTH  write data
//  data_rd     out  DATA_WIDTH  read data, valid only while dram_valid=1
//  dram_valid  out  1           one-cycle pulse: data_rd holds requested word
//  busy        out  1           1 while a read is outstanding (not in ST_IDLE)
//  err         out  1           sticky: read request seen while busy; cleared only by reset
// BEHAVIOUR
//  Reset (srstn=0 at edge): state=ST_IDLE, counter=0, dram_valid=0, data_rd=0, busy=0, err=0.
//   Storage contents are not cleared. Reset mid-read drops the read; no dram_valid is issued.
//  FSM: ST_IDLE -> ST_RD_WAIT when dram_en_rd=1 (latch addr_rd, counter=RD_LATENCY-1).
//   ST_RD_WAIT: counter decrements each cycle; at counter==0 -> ST_RD_RESP.
//   ST_RD_RESP: dram_valid=1 and data_rd registered for exactly this cycle; -> ST_IDLE.
//   RD_LATENCY=1: ST_IDLE -> ST_RD_RESP directly (valid the cycle after acceptance).
//  Latency: request accepted at edge N -> dram_valid high during cycle N+RD_LATENCY.
//  dram_en_rd in ST_RD_WAIT: ignored, sets err. dram_en_rd in ST_RD_RESP: ignored, no err
//   (lets the initiator drop en_rd the cycle it sees valid). Next accept earliest in ST_IDLE.
//  Writes: accepted in any state when dram_en_wr=1; mem[addr_wr] <= data_wr at that edge.
//  Read/write hazard: read data is fetched from storage in the ST_RD_RESP-preceding cycle;
//   any write to the latched address committed before that fetch is returned (write-first).
//   Write to same address in the fetch cycle itself: new data_wr is returned (bypass).
//  Simultaneous dram_en_rd and dram_en_wr in ST_IDLE: both accepted.
//  Address >= MEM_DEPTH wraps to low bits; no error.
//  data_rd returns to 0 when dram_valid=0.
// STRUCTURE
//  Shared package/header dram_pkg: ST_IDLE/ST_RD_WAIT/ST_RD_RESP encodings (2-bit),
//   default DATA_WIDTH/ADDR_WIDTH, RD_LATENCY max constant.
//  Sub-module dram_mem_array: single write port, one registered read port, MEM_DEPTH x DATA_WIDTH,
//   write-first bypass inside. dram_resp holds FSM, latency counter, address latch, err.
// TESTING
//  Reset, write 0xDEADBEEF @5, read @5 (RD_LATENCY=2) -> dram_valid 2 cycles later, data_rd=0xDEADBEEF, busy 1->0.
//  Read @7 with en_rd held high until valid, dropped same cycle -> exactly one valid pulse, err=0.
//  Read @9 issued, second en_rd during ST_RD_WAIT -> err=1 sticky, only one valid, data = mem[9].
//  Read @3 accepted, write 0x12345678 @3 in fetch cycle -> data_rd=0x12345678.
//  srstn=0 one cycle into read latency -> no dram_valid, busy=0, err=0; mem contents intact.
//  MEM_DEPTH=16: write 0xA @0x13, read @0x3 -> data_rd=0xA; RD_LATENCY=1 -> valid next cycle.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared constants for the DRAM responder: FSM encodings, default widths and
// the latency counter sizing.
package dram_pkg;

  localparam int unsigned DRAM_DATA_WIDTH = 32;
  localparam int unsigned DRAM_ADDR_WIDTH = 18;

  localparam int unsigned RD_LAT_MAX = 15;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RD_RESP = 2'd2;

endpackage

// File: rtl/dram_mem_array.sv
// Word storage with one write port and one registered read port. A write to the
// address being fetched in the same cycle is forwarded to the read register.
module dram_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Storage is deliberately not reset; contents survive srstn.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register only holds a word in the cycle after a fetch, zero otherwise.
  always_comb begin
    rdata_d = '0;
    if (re_i) begin
      rdata_d = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dram_resp.sv
// DRAM-side responder: fixed-latency reads with a one-cycle dram_valid pulse,
// same-cycle writes, sticky err on a read request while a read is in flight.
module dram_resp
  import dram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DRAM_ADDR_WIDTH,
  parameter int unsigned MEM_DEPTH  = 2 ** ADDR_WIDTH,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  dram_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             err_q, err_d;
  logic             fetch_en;
  logic [IDX_W-1:0] fetch_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_dec = cnt_q - CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (dram_en_rd) begin
          addr_d = addr_rd[IDX_W-1:0];
          if (RD_LATENCY <= 1) begin
            state_d = ST_RD_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end
        end
      end
      ST_RD_WAIT: begin
        if (dram_en_rd) begin
          err_d = 1'b1;
        end
        cnt_d = cnt_dec;
        if (cnt_dec == '0) begin
          state_d = ST_RD_RESP;
        end
      end
      ST_RD_RESP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The word is fetched on the edge that enters ST_RD_RESP; with a latency of one
  // that edge is the accepting edge, so the address comes straight from addr_rd.
  assign fetch_en  = (state_d == ST_RD_RESP);
  assign fetch_idx = (state_q == ST_IDLE) ? addr_rd[IDX_W-1:0] : addr_q;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  dram_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .srstn   (srstn),
    .we_i    (dram_en_wr),
    .waddr_i (addr_wr[IDX_W-1:0]),
    .wdata_i (data_wr),
    .re_i    (fetch_en),
    .raddr_i (fetch_idx),
    .rdata_o (data_rd)
  );

  assign dram_valid = (state_q == ST_RD_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp: a default instance (latency 2, full depth) driven
// from a vector table, and a small instance (depth 16, latency 1) driven by hand.
module tb_dram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_rstn, a_rd, a_wr;
  logic [17:0] a_ra, a_wa;
  logic [31:0] a_wd, a_data;
  logic        a_valid, a_busy, a_err;

  // Instance B: 16 words, latency 1
  logic        b_rstn, b_rd, b_wr;
  logic [7:0]  b_ra, b_wa;
  logic [31:0] b_wd, b_data;
  logic        b_valid, b_busy, b_err;

  dram_resp u_a (
    .clk        (clk),
    .srstn      (a_rstn),
    .dram_en_rd (a_rd),
    .addr_rd    (a_ra),
    .dram_en_wr (a_wr),
    .addr_wr    (a_wa),
    .data_wr    (a_wd),
    .data_rd    (a_data),
    .dram_valid (a_valid),
    .busy       (a_busy),
    .err        (a_err)
  );

  dram_resp #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .MEM_DEPTH  (16),
    .RD_LATENCY (1)
  ) u_b (
    .clk        (clk),
    .srstn      (b_rstn),
    .dram_en_rd (b_rd),
    .addr_rd    (b_ra),
    .dram_en_wr (b_wr),
    .addr_wr    (b_wa),
    .data_wr    (b_wd),
    .data_rd    (b_data),
    .dram_valid (b_valid),
    .busy       (b_busy),
    .err        (b_err)
  );

  typedef struct {
    logic        rstn;
    logic        rd;
    logic [17:0] ra;
    logic        wr;
    logic [17:0] wa;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
    logic        eb;
    logic        ee;
  } vec_t;

  localparam int unsigned NVEC = 30;
  vec_t vecs [NVEC];

  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t mk(logic rstn, logic rd, logic [17:0] ra, logic wr,
                              logic [17:0] wa, logic [31:0] wd, logic ev,
                              logic [31:0] ed, logic eb, logic ee);
    vec_t v;
    v.rstn = rstn; v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd;
    v.ev = ev; v.ed = ed; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step_b(input int idx, input logic rd, input logic [7:0] ra,
                        input logic wr, input logic [7:0] wa, input logic [31:0] wd,
                        input logic ev, input logic [31:0] ed, input logic eb,
                        input logic ee);
    b_rd = rd; b_ra = ra; b_wr = wr; b_wa = wa; b_wd = wd;
    @(posedge clk);
    #1;
    chk("b_valid", idx, {31'd0, b_valid}, {31'd0, ev});
    chk("b_data",  idx, b_data, ed);
    chk("b_busy",  idx, {31'd0, b_busy}, {31'd0, eb});
    chk("b_err",   idx, {31'd0, b_err}, {31'd0, ee});
  endtask

  initial begin
    // rstn rd addr wr addr data | valid data busy err
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[2]  = mk(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0,            0, 0);
    vecs[3]  = mk(1, 1, 5, 0, 0, 0,            0, 0,            1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0,            1, 32'hDEADBEEF, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[6]  = mk(1, 0, 0, 1, 7, 32'h00C0FFEE, 0, 0,            0, 0);
    vecs[7]  = mk(1, 1, 7, 0, 0, 0,            0, 0,            1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0,            1, 32'h00C0FFEE, 1, 0);
    // en_rd high while valid is showing: ignored, no err, no new read
    vecs[9]  = mk(1, 1, 7, 0, 0, 0,            0, 0,            0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[11] = mk(1, 0, 0, 1, 3, 32'h33333333, 0, 0,            0, 0);
    vecs[12] = mk(1, 1, 3, 0, 0, 0,            0, 0,            1, 0);
    // write to the latched address in the fetch cycle is returned
    vecs[13] = mk(1, 0, 0, 1, 3, 32'h12345678, 1, 32'h12345678, 1, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    // simultaneous read and write to the same address in idle
    vecs[15] = mk(1, 1, 4, 1, 4, 32'h00000044, 0, 0,            1, 0);
    vecs[16] = mk(1, 0, 0, 0, 0, 0,            1, 32'h00000044, 1, 0);
    vecs[17] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[18] = mk(1, 0, 0, 1, 9, 32'h99990009, 0, 0,            0, 0);
    vecs[19] = mk(1, 1, 9, 0, 0, 0,            0, 0,            1, 0);
    // second request during wait (different address) sets err, is not taken
    vecs[20] = mk(1, 1, 5, 0, 0, 0,            1, 32'h99990009, 1, 1);
    vecs[21] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 1);
    vecs[22] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 1);
    vecs[23] = mk(1, 1, 5, 0, 0, 0,            0, 0,            1, 1);
    // reset one cycle into latency drops the read and clears err
    vecs[24] = mk(0, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[25] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[26] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 0);
    vecs[27] = mk(1, 1, 5, 0, 0, 0,            0, 0,            1, 0);
    vecs[28] = mk(1, 0, 0, 0, 0, 0,            1, 32'hDEADBEEF, 1, 0);
    vecs[29] = mk(1, 0, 0, 0, 0, 0,            0, 0,            0, 0);

    b_rstn = 1'b0; b_rd = 1'b0; b_ra = '0; b_wr = 1'b0; b_wa = '0; b_wd = '0;
    a_rstn = 1'b0; a_rd = 1'b0; a_ra = '0; a_wr = 1'b0; a_wa = '0; a_wd = '0;

    for (int i = 0; i < NVEC; i++) begin
      a_rstn = vecs[i].rstn;
      a_rd   = vecs[i].rd;
      a_ra   = vecs[i].ra;
      a_wr   = vecs[i].wr;
      a_wa   = vecs[i].wa;
      a_wd   = vecs[i].wd;
      @(posedge clk);
      #1;
      chk("a_valid", i, {31'd0, a_valid}, {31'd0, vecs[i].ev});
      chk("a_data",  i, a_data, vecs[i].ed);
      chk("a_busy",  i, {31'd0, a_busy}, {31'd0, vecs[i].eb});
      chk("a_err",   i, {31'd0, a_err}, {31'd0, vecs[i].ee});
    end
    a_rd = 1'b0; a_wr = 1'b0;

    // Instance B: reset state
    b_rstn = 1'b0;
    step_b(100, 0, 8'h00, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);
    b_rstn = 1'b1;
    // 0x13 wraps to word 3 in a 16-word array
    step_b(101, 0, 8'h00, 1, 8'h13, 32'h0000000A, 0, 32'h0, 0, 0);
    step_b(102, 1, 8'h03, 0, 8'h00, 32'h0, 1, 32'h0000000A, 1, 0);
    // en_rd still high in the response cycle: ignored
    step_b(103, 1, 8'h03, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);
    step_b(104, 0, 8'h00, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);
    // latency 1: accept and fetch share the edge, so the same-cycle write is bypassed
    step_b(105, 1, 8'h05, 1, 8'h15, 32'h00000055, 1, 32'h00000055, 1, 0);
    step_b(106, 0, 8'h00, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);
    step_b(107, 1, 8'h25, 0, 8'h00, 32'h0, 1, 32'h00000055, 1, 0);
    step_b(108, 0, 8'h00, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
